pellet_ctrl: RTL and testbench
==============================

# pellet_ctrl

Maze-side pellet and fright-timer controller; the source end of the ghost power-pellet interface. Consumes Pac-Man tile-eat events, keeps the score and remaining-pellet count, and issues the one-cycle `power_pellet` pulse that drives every ghost FSM into its frightened state. It also owns the fright window and its warning phase, so the ghosts and the display share one timing reference.

## Interface
- `TOTAL_PELLETS`, 244: pellets loaded per level (dots plus power pellets).
- `FRIGHT_CYCLES`, 600: length of the fright window in cycles; must be ≥ 2.
- `WARN_CYCLES`, 120: number of final fright cycles flagged as warning; must be < `FRIGHT_CYCLES`.
- `SCORE_W`, 20: score width.
- `DOT_PTS`, 10 / `POWER_PTS`, 50 / `GHOST_PTS`, 200: point values.
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `level_start`  in  1  one-cycle pulse that loads a new level.
- `eat_dot`  in  1  Pac-Man ate a regular dot this cycle.
- `eat_power`  in  1  Pac-Man ate a power pellet this cycle.
- `ghost_eaten`  in  1  Pac-Man ate a frightened ghost this cycle.
- `power_pellet`  out  1  one-cycle pulse to the ghost FSMs.
- `frightened`  out  1  high for the whole fright window.
- `fright_warn`  out  1  high during the last `WARN_CYCLES` cycles of the window.
- `score`  out  `SCORE_W`  accumulated score.
- `pellets_left`  out  `$clog2(TOTAL_PELLETS+1)`  pellets remaining.
- `level_clear`  out  1  high while the level is cleared.

## Operation
- FSM states:
  - IDLE (reset state).
  - NORMAL.
  - FRIGHT.
  - CLEAR.
- All outputs are registered.
- Reset values: `power_pellet`, `frightened`, `fright_warn` and `level_clear` = 0; `score` = 0; `pellets_left` = 0; fright timer = 0; combo = 0.
- `level_start`, from any state:
  - `pellets_left` ← `TOTAL_PELLETS`; timer and combo ← 0; next state NORMAL.
  - `score` is preserved.
  - Eat inputs in the same cycle are ignored.
- In IDLE and CLEAR, all eat inputs and `ghost_eaten` are ignored.
- Accepted eat (NORMAL/FRIGHT with `pellets_left` > 0):
  - `pellets_left` decrements by exactly 1.
  - `eat_power` has priority over `eat_dot` in the same cycle; the dot is dropped, with no score and no decrement.
- `eat_power` accepted in NORMAL or FRIGHT:
  - `score` += `POWER_PTS`.
  - Timer ← `FRIGHT_CYCLES`; combo ← 0; `power_pellet` pulses; state FRIGHT.
  - Accepting it while already in FRIGHT retriggers the window: full reload plus a new pulse.
- `eat_dot` accepted: `score` += `DOT_PTS`.
- FRIGHT timer:
  - Decrements by 1 each cycle it is not reloaded.
  - At timer = 1 with no reload, the next state is NORMAL.
  - `fright_warn` = FRIGHT and timer ≤ `WARN_CYCLES`.
- `ghost_eaten`:
  - Scores only in FRIGHT; ignored in every other state.
  - Sums with a same-cycle dot or power score.
  - Point value is set by the combo (see Configuration).
- Last pellet (decrement to 0):
  - Next state is CLEAR, `level_clear` = 1, and fright ends immediately (`frightened` and `fright_warn` = 0).
  - If the last pellet is a power pellet, it scores `POWER_PTS` but issues no `power_pellet` pulse.
- `score` saturates at 2^`SCORE_W`−1 and never wraps.
- `reset_n` asserted mid-fright clears all state asynchronously; `frightened` drops without waiting for a clock edge.

## Timing
- An event sampled at edge k is visible from edge k, i.e. during cycle k+1. This applies to `score`, `pellets_left` and state outputs.
- `power_pellet` is high for exactly the one cycle after the accepted `eat_power` edge, coincident with the first `frightened` cycle.
- With no retrigger, `frightened` stays high for exactly `FRIGHT_CYCLES` consecutive cycles.
- `fright_warn` is high for exactly its final `WARN_CYCLES` cycles.
- A retrigger on the last fright cycle extends the window with no gap: `frightened` does not drop.
- `level_clear` stays high until `level_start` or reset.

## Configuration
- `PELLET_CTRL_GHOST_COMBO_EN` defined:
  - Successive ghosts within one fright window score `GHOST_PTS` × 1, 2, 4, 8: 200, 400, 800, 1600.
  - The combo is a 2-bit counter that saturates at 8×.
  - The combo resets on each accepted `eat_power` and on `level_start`.
- Macro undefined:
  - Every ghost scores `GHOST_PTS`.
  - The combo counter is not built.

## Test plan
Bench parameters: `TOTAL_PELLETS`=5, `FRIGHT_CYCLES`=8, `WARN_CYCLES`=3.
- Reset then `level_start` → `pellets_left`=5, `score`=0, all flags 0. Three `eat_dot` pulses → `score`=30, `pellets_left`=2.
- `eat_power` at edge k → `power_pellet`=1 for one cycle only. `frightened`=1 for 8 cycles; `fright_warn`=1 on the last 3 of them; then NORMAL.
- Retrigger `eat_power` on the 6th fright cycle → second pulse; `frightened` continues unbroken for 8 further cycles.
- `ghost_eaten` ×5 in FRIGHT → +200/400/800/1600/1600 with the macro, +200 each without. `ghost_eaten` in NORMAL → `score` unchanged.
- `eat_dot` and `eat_power` in the same cycle → +50 only, `pellets_left` −1. Last pellet eaten as power → `level_clear`=1, no `power_pellet` pulse, `frightened`=0.
- `reset_n` low mid-fright → `frightened` and `score` go to 0 asynchronously. `score` preset near 2^20−1 plus a dot → saturates at 1048575.

Source files
------------

// File: rtl/pellet_ctrl.sv
// Maze-side pellet, score and fright-timer controller; sources the power_pellet pulse.
// Optional ghost combo scoring (x1/x2/x4/x8) is built when PELLET_CTRL_GHOST_COMBO_EN is defined.
module pellet_ctrl #(
   parameter int TOTAL_PELLETS = 244,
   parameter int FRIGHT_CYCLES = 600,
   parameter int WARN_CYCLES   = 120,
   parameter int SCORE_W       = 20,
   parameter int DOT_PTS       = 10,
   parameter int POWER_PTS     = 50,
   parameter int GHOST_PTS     = 200,
   localparam int PL_W         = $clog2(TOTAL_PELLETS + 1)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               level_start,
   input  logic               eat_dot,
   input  logic               eat_power,
   input  logic               ghost_eaten,
   output logic               power_pellet,
   output logic               frightened,
   output logic               fright_warn,
   output logic [SCORE_W-1:0] score,
   output logic [PL_W-1:0]    pellets_left,
   output logic               level_clear
);

   localparam int TM_W = $clog2(FRIGHT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, NORMAL, FRIGHT, CLEAR} state_t;

   state_t             state_q, state_d;
   logic [TM_W-1:0]    timer_q, timer_d;
   logic [PL_W-1:0]    pellets_d;
   logic [SCORE_W-1:0] score_d;
   logic               pulse_d;
   logic [31:0]        inc;
   logic [31:0]        ghost_val;
`ifdef PELLET_CTRL_GHOST_COMBO_EN
   logic [1:0]         combo_q, combo_d;
`endif

   // Score never wraps: any carry out of SCORE_W bits pins it at all-ones.
   function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                   input logic [31:0]        b);
      logic [SCORE_W+32:0] s;
      s = (SCORE_W+33)'(a) + (SCORE_W+33)'(b);
      if (s[SCORE_W+32:SCORE_W] != '0) return '1;
      return s[SCORE_W-1:0];
   endfunction

`ifdef PELLET_CTRL_GHOST_COMBO_EN
   assign ghost_val = 32'(GHOST_PTS) << combo_q;
`else
   assign ghost_val = 32'(GHOST_PTS);
`endif

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      pellets_d = pellets_left;
      score_d   = score;
      pulse_d   = 1'b0;
      inc       = '0;
`ifdef PELLET_CTRL_GHOST_COMBO_EN
      combo_d   = combo_q;
`endif
      if (level_start) begin
         pellets_d = PL_W'(TOTAL_PELLETS);
         timer_d   = '0;
         state_d   = NORMAL;
`ifdef PELLET_CTRL_GHOST_COMBO_EN
         combo_d   = '0;
`endif
      end else if (state_q == NORMAL || state_q == FRIGHT) begin
         if (state_q == FRIGHT) begin
            if (ghost_eaten) begin
               inc = ghost_val;
`ifdef PELLET_CTRL_GHOST_COMBO_EN
               combo_d = (combo_q == 2'd3) ? 2'd3 : combo_q + 2'd1;
`endif
            end
            if (timer_q == TM_W'(1)) begin
               state_d = NORMAL;
               timer_d = '0;
            end else begin
               timer_d = timer_q - TM_W'(1);
            end
         end
         // Power beats a same-cycle dot; the dot is simply dropped.
         if (pellets_left != '0 && (eat_power || eat_dot)) begin
            pellets_d = pellets_left - PL_W'(1);
            if (eat_power) begin
               inc     = inc + 32'(POWER_PTS);
               timer_d = TM_W'(FRIGHT_CYCLES);
               state_d = FRIGHT;
               pulse_d = 1'b1;
`ifdef PELLET_CTRL_GHOST_COMBO_EN
               combo_d = '0;
`endif
            end else begin
               inc = inc + 32'(DOT_PTS);
            end
            // Last pellet ends the level and cancels any fright, pulse included.
            if (pellets_left == PL_W'(1)) begin
               state_d = CLEAR;
               timer_d = '0;
               pulse_d = 1'b0;
            end
         end
         score_d = sat_add(score, inc);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         timer_q      <= '0;
         pellets_left <= '0;
         score        <= '0;
         power_pellet <= 1'b0;
         frightened   <= 1'b0;
         fright_warn  <= 1'b0;
         level_clear  <= 1'b0;
`ifdef PELLET_CTRL_GHOST_COMBO_EN
         combo_q      <= '0;
`endif
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         pellets_left <= pellets_d;
         score        <= score_d;
         power_pellet <= pulse_d;
         frightened   <= (state_d == FRIGHT);
         fright_warn  <= (state_d == FRIGHT) && (timer_d <= TM_W'(WARN_CYCLES));
         level_clear  <= (state_d == CLEAR);
`ifdef PELLET_CTRL_GHOST_COMBO_EN
         combo_q      <= combo_d;
`endif
      end
   end

endmodule

// File: tb/tb_pellet_ctrl.sv
// Scoreboard bench for pellet_ctrl: a rule-level reference model queues expected outputs per cycle,
// and a monitor pops and compares them one step after each rising edge.
module tb_pellet_ctrl;

   localparam int     T   = 5;
   localparam int     F   = 8;
   localparam int     W   = 3;
   localparam int     SW  = 20;
   localparam longint MAX = (64'd1 << SW) - 1;
   localparam int     PW  = $clog2(T + 1);

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          level_start = 1'b0, eat_dot = 1'b0, eat_power = 1'b0, ghost_eaten = 1'b0;
   logic          power_pellet, frightened, fright_warn, level_clear;
   logic [SW-1:0] score;
   logic [PW-1:0] pellets_left;

   pellet_ctrl #(
      .TOTAL_PELLETS(T), .FRIGHT_CYCLES(F), .WARN_CYCLES(W), .SCORE_W(SW),
      .DOT_PTS(10), .POWER_PTS(50), .GHOST_PTS(200)
   ) dut (
      .clk(clk), .reset_n(reset_n), .level_start(level_start), .eat_dot(eat_dot),
      .eat_power(eat_power), .ghost_eaten(ghost_eaten), .power_pellet(power_pellet),
      .frightened(frightened), .fright_warn(fright_warn), .score(score),
      .pellets_left(pellets_left), .level_clear(level_clear)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit     pulse;
      bit     fr;
      bit     warn;
      bit     clr;
      longint score;
      int     pellets;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   errors = 0;
   int   checks = 0;

   // Reference model: a level is "live" when loaded and not cleared; fright_left counts remaining
   // frightened cycles; ghosts counts ghosts eaten since the last power pellet.
   bit     m_live, m_clear;
   int     m_fright, m_ghosts, m_pellets;
   longint m_score;

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   function automatic longint ghost_value(input int n);
`ifdef PELLET_CTRL_GHOST_COMBO_EN
      return 200 * (1 << ((n > 3) ? 3 : n));
`else
      return 200;
`endif
   endfunction

   task automatic model_reset();
      m_live = 0; m_clear = 0; m_fright = 0; m_ghosts = 0; m_pellets = 0; m_score = 0;
   endtask

   task automatic model_step(input bit ls, input bit d, input bit p, input bit g);
      bit     pulse = 0;
      longint gain  = 0;
      int     nf;
      exp_t   x;
      if (ls) begin
         m_pellets = T; m_fright = 0; m_ghosts = 0; m_live = 1; m_clear = 0;
      end else if (m_live && !m_clear) begin
         nf = (m_fright > 0) ? m_fright - 1 : 0;
         if (g && m_fright > 0) begin
            gain += ghost_value(m_ghosts);
            m_ghosts++;
         end
         if (m_pellets > 0 && (p || d)) begin
            m_pellets--;
            if (p) begin
               gain += 50; nf = F; m_ghosts = 0; pulse = 1;
            end else begin
               gain += 10;
            end
            if (m_pellets == 0) begin
               m_clear = 1; nf = 0; pulse = 0;
            end
         end
         m_fright = nf;
         m_score  = (m_score + gain > MAX) ? MAX : m_score + gain;
      end
      x.pulse   = pulse;
      x.fr      = (m_fright > 0);
      x.warn    = (m_fright > 0) && (m_fright <= W);
      x.clr     = m_clear;
      x.score   = m_score;
      x.pellets = m_pellets;
      q.push_back(x);
   endtask

   task automatic cyc(input bit ls, input bit d, input bit p, input bit g);
      @(negedge clk);
      level_start = ls; eat_dot = d; eat_power = p; ghost_eaten = g;
      model_step(ls, d, p, g);
   endtask

   always @(posedge clk) begin
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("power_pellet", longint'(power_pellet), longint'(e.pulse));
         chk("frightened",   longint'(frightened),   longint'(e.fr));
         chk("fright_warn",  longint'(fright_warn),  longint'(e.warn));
         chk("level_clear",  longint'(level_clear),  longint'(e.clr));
         chk("score",        longint'(score),        e.score);
         chk("pellets_left", longint'(pellets_left), longint'(e.pellets));
      end
   end

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      chk("reset score",   longint'(score), 0);
      chk("reset pellets", longint'(pellets_left), 0);
      chk("reset flags",   longint'({power_pellet, frightened, fright_warn, level_clear}), 0);
      reset_n = 1'b1;

      // IDLE ignores eats; level_start ignores same-cycle eats
      cyc(0, 0, 0, 0);
      cyc(0, 1, 1, 1);
      cyc(1, 1, 0, 0);
      repeat (3) cyc(0, 1, 0, 0);
      cyc(0, 0, 0, 1);
      // full fright window, then back to normal
      cyc(0, 0, 1, 0);
      repeat (10) cyc(0, 0, 0, 0);
      // retrigger on the 6th fright cycle, then ghosts
      cyc(1, 0, 0, 0);
      cyc(0, 0, 1, 0);
      repeat (5) cyc(0, 0, 0, 0);
      cyc(0, 0, 1, 0);
      repeat (5) cyc(0, 0, 0, 1);
      repeat (6) cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 1);
      // dot+power together, then last pellet as power
      cyc(0, 1, 1, 0);
      cyc(0, 1, 0, 0);
      cyc(0, 0, 1, 0);
      repeat (3) cyc(0, 0, 0, 0);
      cyc(0, 0, 1, 0);
      repeat (3) cyc(0, 1, 1, 1);
      // retrigger exactly on the final fright cycle
      cyc(1, 0, 0, 0);
      cyc(0, 0, 1, 0);
      repeat (7) cyc(0, 0, 0, 0);
      cyc(0, 0, 1, 0);
      repeat (3) cyc(0, 0, 0, 0);

      // asynchronous reset mid-fright
      @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      chk("async frightened", longint'(frightened), 0);
      chk("async score",      longint'(score), 0);
      chk("async warn",       longint'(fright_warn), 0);
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;

      // randomized traffic
      cyc(1, 0, 0, 0);
      for (int i = 0; i < 400; i++)
         cyc($urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);

      // pump score to saturation through ghost streaks
      for (int lv = 0; lv < 400 && m_score < MAX; lv++) begin
         cyc(1, 0, 0, 0);
         for (int k = 0; k < 4; k++) begin
            cyc(0, 0, 1, 1);
            repeat (7) cyc(0, 0, 0, 1);
         end
      end
      cyc(1, 0, 0, 0);
      cyc(0, 1, 0, 0);
      cyc(0, 0, 1, 1);
      repeat (2) cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 0);
      repeat (2) @(negedge clk);
      chk("saturated score", longint'(score), 1048575);
      chk("queue drained", longint'(q.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
